// File: rtl/arbitro_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package arbitro_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} estadoT;

  localparam int unsigned NUM_REGS    = 32;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/arbitro_round_robin.sv
// Combinational round-robin picker: first valid index at or after rrPtr, cyclically.
module arbitro_round_robin #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               anyValid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyValid = 1'b0;
    cand     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = IDX_W'((int'(rrPtr) + k) % int'(NUM_REQ));
      if (!anyValid && valid[cand]) begin
        anyValid    = 1'b1;
        grant[cand] = 1'b1;
        grantIdx    = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Register-file write-port controller: clears all registers after reset,
// then shares the single write port among requesters round-robin.
module arbitro_escrita_banco
  import arbitro_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_dado,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         RD,
  output logic [DATA_W-1:0]         dadosEscrita,
  output logic                      init_done,
  output logic [CNT_W-1:0]          conflitos
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  estadoT            estado, proxEstado;
  logic [ADDR_W-1:0] contInit;
  logic [IDX_W-1:0]  rrPtr;
  logic [NUM_REQ-1:0] concessao;
  logic [IDX_W-1:0]  idxConcessao;
  logic              algumValido;
  logic              transferencia;
  logic              ultimoInit;
  logic              conflito;
  logic [ADDR_W-1:0] rdSlot   [NUM_REQ];
  logic [DATA_W-1:0] dadoSlot [NUM_REQ];
  logic [ADDR_W-1:0] rdSel;
  logic [DATA_W-1:0] dadoSel;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : gSlots
    assign rdSlot[i]   = req_rd[i*ADDR_W +: ADDR_W];
    assign dadoSlot[i] = req_dado[i*DATA_W +: DATA_W];
  end

  assign rdSel      = rdSlot[idxConcessao];
  assign dadoSel    = dadoSlot[idxConcessao];
  assign ultimoInit = (contInit == ADDR_W'(NUM_REGS - 1));
  // Two or more requests pending at once.
  assign conflito   = |(req_valid & (req_valid - NUM_REQ'(1)));

  arbitro_round_robin #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uRoundRobin (
    .valid    (req_valid),
    .rrPtr    (rrPtr),
    .grant    (concessao),
    .grantIdx (idxConcessao),
    .anyValid (algumValido)
  );

  always_ff @(posedge clock) begin
    if (reset) estado <= INIT;
    else       estado <= proxEstado;
  end

  always_comb begin
    proxEstado    = estado;
    req_ready     = '0;
    transferencia = 1'b0;
    unique case (estado)
      INIT: if (ultimoInit) proxEstado = RUN;
      RUN: begin
        req_ready     = concessao;
        transferencia = algumValido;
      end
    endcase
  end

  // Write-port registers, clear sweep counter, arbitration pointer and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      contInit     <= '0;
      rrPtr        <= '0;
      regWrite     <= 1'b0;
      RD           <= '0;
      dadosEscrita <= '0;
      init_done    <= 1'b0;
      conflitos    <= '0;
    end else begin
      unique case (estado)
        INIT: begin
          regWrite     <= 1'b1;
          RD           <= contInit;
          dadosEscrita <= '0;
          contInit     <= contInit + ADDR_W'(1);
          if (ultimoInit) init_done <= 1'b1;
        end
        RUN: begin
          if (conflito && (conflitos != '1)) conflitos <= conflitos + CNT_W'(1);
          if (transferencia) begin
            // Writes to $zero are accepted but never reach the register file.
            regWrite     <= (rdSel != ADDR_W'(REG_ZERO));
            RD           <= rdSel;
            dadosEscrita <= dadoSel;
            rrPtr        <= (idxConcessao == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : idxConcessao + IDX_W'(1);
          end else begin
            regWrite <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/arbitro_escrita_banco.md
Name: arbitro_escrita_banco

Overview:
Write-port controller for the 32x32 register file (single write port: regWrite, RD, dadosEscrita).
- After reset, sequences a clear of all 32 registers to zero, because the register file has no reset of its own.
- Afterwards, shares the write port among NUM_REQ writeback requesters using round-robin arbitration with valid/ready handshakes.
- Sits between the writeback sources (ALU, load unit, I/O input) and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, data width.
- ADDR_W, 5, register address width (32 registers).
- CNT_W, 16, width of the conflict statistics counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_rd  in  NUM_REQ*ADDR_W  destination register per requester; slot i is bits [i*ADDR_W +: ADDR_W].
- req_dado  in  NUM_REQ*DATA_W  write data per requester; slot i is bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs on valid&ready.
- regWrite  out  1  register file write enable (registered).
- RD  out  ADDR_W  register file destination (registered).
- dadosEscrita  out  DATA_W  register file write data (registered).
- init_done  out  1  high once the clear sequence has completed.
- conflitos  out  CNT_W  saturating count of cycles with 2 or more valid requests in RUN.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While reset is high at a posedge:
  - state <= INIT, init counter <= 0, rr_ptr <= 0.
  - regWrite <= 0, RD <= 0, dadosEscrita <= 0.
  - init_done <= 0, conflitos <= 0.
- FSM has two states: INIT and RUN.
- INIT state:
  - req_ready = 0 (all requesters).
  - At each posedge: regWrite <= 1, RD <= cnt, dadosEscrita <= 0, cnt <= cnt+1.
  - When cnt==31 is issued: state <= RUN, init_done <= 1.
  - regWrite is therefore high for exactly 32 consecutive cycles (RD 0..31), starting the cycle after reset deasserts.
- RUN, grant selection:
  - Grant g is the first index with req_valid set, searching cyclically from rr_ptr.
  - req_ready = one-hot(g), computed combinationally from req_valid and rr_ptr.
  - req_ready is all zero if no request is valid.
  - ready never asserts for a non-valid requester.
- RUN, on transfer:
  - regWrite <= (req_rd[g] != 0), RD <= req_rd[g], dadosEscrita <= req_dado[g].
  - rr_ptr <= (g+1) mod NUM_REQ.
- RUN, no transfer: regWrite <= 0; RD and dadosEscrita hold their previous values.
- Latency: a handshake at edge N drives regWrite high after edge N; the register file captures the write at edge N+1.
- Throughput: one write per cycle; a continuously valid requester wins at least once every NUM_REQ cycles.
- Register $zero: a write to register 0 is accepted (ready asserted, rr_ptr advances) but regWrite stays 0, so $zero remains 0.
- Requester contract: req_rd and req_dado are held stable while valid is high and ready is low. Violations are not checked.
- conflitos: in RUN, increments on any cycle where popcount(req_valid) >= 2; saturates at all ones. It is 0 during INIT.
- Reset mid-operation (in INIT or RUN): restarts the full INIT sweep. An in-flight output write is dropped (regWrite <= 0). Pending requests simply remain valid.
- Reset has priority over all other events in the same cycle.

Decomposition:
- Package arbitro_pkg holds: state enum {INIT, RUN}, NUM_REGS=32, REG_ZERO=5'd0, and the default widths.
- One natural sub-module: arbitro_round_robin.
  - Combinational; inputs are the valid vector and rr_ptr.
  - Outputs are the one-hot grant, the grant index, and any_valid.
  - It is reused by the memory-port controller.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Clear sequence: release reset. regWrite=1 for 32 cycles with RD=0,1,...,31 and dadosEscrita=0; init_done rises in the cycle after the RD=31 write; req_ready stays 0 throughout.
- Single requester: after init, req0 writes RD=5, dado=0xDEADBEEF. Same cycle req_ready=3'b001; next cycle regWrite=1, RD=5, dadosEscrita=0xDEADBEEF; the register file reads back 0xDEADBEEF.
- Round-robin fairness: all 3 requesters valid continuously. Grants are 0,1,2,0,1,2; conflitos increments every cycle; regWrite stays high continuously.
- $zero protection: req1 writes RD=0, dado=0xFFFFFFFF. req_ready[1]=1, regWrite stays 0, register 0 still reads 0; the next grant search starts at index 2.
- Reset mid-RUN: assert reset while req2 is valid and mid-transfer. regWrite=0 the next cycle, then the full 32-cycle INIT sweep reruns; req2 is granted first after init_done.
- Conflict saturation: with CNT_W=4, hold 2 valids for 20 cycles. conflitos reads 15 and holds.
